// File: rtl/fetch_unit_pkg.sv
// Shared types for the instruction-fetch stage: FSM states, hold-buffer entry and IF/ID payload.
package fetch_unit_pkg;

  typedef enum logic [1:0] {
    FETCH  = 2'd0,
    HOLD   = 2'd1,
    HALTED = 2'd2
  } fetch_state_t;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
  } fetch_buf_t;

  typedef struct packed {
    logic        valid;
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] npc;
  } ifid_t;

  localparam logic [5:0] HALT_OP = 6'b111111;

  function automatic ifid_t pack_ifid(input logic        valid,
                                      input logic [31:0] instr,
                                      input logic [31:0] pc,
                                      input logic [31:0] npc);
    ifid_t r;
    r.valid = valid;
    r.instr = instr;
    r.pc    = pc;
    r.npc   = npc;
    return r;
  endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Fetch-stage bus: icache request/response, pipeline control inputs and IF/ID-bound outputs.
interface fetch_unit_if;
  logic        imemREN;
  logic [31:0] imemaddr;
  logic        ihit;
  logic [31:0] imemload;
  logic        advance;
  logic        flush;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        if_valid;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic [31:0] if_npc;
  logic        halted;

  modport master (
    output imemREN, imemaddr, if_valid, if_instr, if_pc, if_npc, halted,
    input  ihit, imemload, advance, flush, redirect, redirect_pc
  );

  modport slave (
    input  imemREN, imemaddr, if_valid, if_instr, if_pc, if_npc, halted,
    output ihit, imemload, advance, flush, redirect, redirect_pc
  );
endinterface

// File: rtl/fetch_unit_holdbuf.sv
// One-entry buffer keeping a fetched word and its PC while the pipeline is stalled.
module fetch_holdbuf
  import fetch_unit_pkg::*;
(
  input  logic       CLK,
  input  logic       RST,
  input  logic       load,
  input  logic       clear,
  input  fetch_buf_t dIn,
  output logic       valid,
  output fetch_buf_t q
);

  // Clear wins over load so a redirect/flush always empties the entry.
  always_ff @(posedge CLK) begin
    if (RST || clear) begin
      valid <= 1'b0;
      q     <= '{instr: 32'd0, pc: 32'd0};
    end else if (load) begin
      valid <= 1'b1;
      q     <= dIn;
    end else begin
      valid <= valid;
      q     <= q;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: PC register, icache request, stall hold-buffer, redirect and HALT handling.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [5:0]  HALT_OP  = 6'b111111
) (
  input logic          CLK,
  input logic          RST,
  fetch_unit_if.master bus
);
  import fetch_unit_pkg::*;

  fetch_state_t stateReg, stateNext;
  logic [31:0]  pcReg, pcNext, pcPlus4, redirTarget;
  logic         bufLoad, bufClear, bufValid;
  fetch_buf_t   bufQ;
  logic         fetchReq, outValid, liveValid;
  logic [31:0]  outInstr, outPc;

  function automatic logic isHaltWord(input logic [31:0] w);
    return w[31:26] == HALT_OP;
  endfunction

  assign pcPlus4     = pcReg + 32'd4;
  assign redirTarget = {bus.redirect_pc[31:2], 2'b00};

  fetch_holdbuf u_holdbuf (
    .CLK   (CLK),
    .RST   (RST),
    .load  (bufLoad),
    .clear (bufClear),
    .dIn   ('{instr: bus.imemload, pc: pcReg}),
    .valid (bufValid),
    .q     (bufQ)
  );

  // State and PC registers.
  always_ff @(posedge CLK) begin
    if (RST) begin
      stateReg <= FETCH;
      pcReg    <= RESET_PC;
    end else begin
      stateReg <= stateNext;
      pcReg    <= pcNext;
    end
  end

  // Next-state, PC update and IF/ID output selection; redirect > flush > advance/ihit.
  always_comb begin
    stateNext = stateReg;
    pcNext    = pcReg;
    bufLoad   = 1'b0;
    bufClear  = 1'b0;
    fetchReq  = 1'b0;
    outValid  = 1'b0;
    outInstr  = 32'd0;
    outPc     = pcReg;
    case (stateReg)
      FETCH:   fetchReq = 1'b1;
      HOLD: begin
        outValid = bufValid;
        outInstr = bufQ.instr;
        outPc    = bufQ.pc;
      end
      HALTED:  fetchReq = 1'b0;
      default: fetchReq = 1'b0;
    endcase
    if (bus.redirect) begin
      outValid  = 1'b0;
      pcNext    = redirTarget;
      bufClear  = 1'b1;
      stateNext = FETCH;
    end else if (stateReg == HALTED) begin
      stateNext = HALTED;
    end else if (bus.flush) begin
      outValid  = 1'b0;
      bufClear  = 1'b1;
      stateNext = FETCH;
    end else if (stateReg == HOLD) begin
      if (bus.advance) begin
        pcNext    = pcPlus4;
        bufClear  = 1'b1;
        stateNext = isHaltWord(bufQ.instr) ? HALTED : FETCH;
      end else begin
        stateNext = HOLD;
      end
    end else if (stateReg != FETCH) begin
      bufClear  = 1'b1;
      stateNext = FETCH;
    end else if (bus.ihit) begin
      outValid = 1'b1;
      outInstr = bus.imemload;
      if (bus.advance) begin
        pcNext    = pcPlus4;
        stateNext = isHaltWord(bus.imemload) ? HALTED : FETCH;
      end else begin
        bufLoad   = 1'b1;
        stateNext = HOLD;
      end
    end else begin
      stateNext = FETCH;
    end
  end

  assign liveValid    = outValid & ~RST;
  assign bus.imemREN  = fetchReq;
  assign bus.imemaddr = pcReg;
  assign bus.if_valid = liveValid;
  assign bus.if_instr = liveValid ? outInstr : 32'd0;
  assign bus.if_pc    = outPc;
  assign bus.if_npc   = outPc + 32'd4;
  assign bus.halted   = (stateReg == HALTED);

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios plus randomized traffic against a behavioural model.
module tb_fetch_unit;
  import fetch_unit_pkg::*;

  logic CLK = 1'b0;
  logic RST = 1'b1;
  always #5 CLK = ~CLK;

  fetch_unit_if bus();

  fetch_unit #(.RESET_PC(32'h0000_0000), .HALT_OP(6'b111111)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  int errors = 0;
  int checks = 0;

  // Behavioural model: architectural PC, whether a word is parked, whether fetch is halted.
  logic [31:0] mPc   = 32'h0;
  logic [31:0] mBuf  = 32'h0;
  bit          mHold = 1'b0;
  bit          mHalt = 1'b0;

  function automatic logic [31:0] rndInstr();
    return {6'($urandom_range(0, 62)), 26'($urandom)};
  endfunction

  function automatic logic [130:0] actOut();
    return {bus.imemREN, bus.imemaddr, bus.if_valid, bus.if_instr, bus.if_pc, bus.if_npc, bus.halted};
  endfunction

  function automatic logic [130:0] expOut();
    logic        ren, v;
    logic [31:0] ins;
    bit          killed;
    killed = bus.redirect || bus.flush;
    if (mHalt) begin
      ren = 1'b0; v = 1'b0; ins = 32'd0;
    end else if (mHold) begin
      ren = 1'b0; v = !killed; ins = mBuf;
    end else begin
      ren = 1'b1; v = bus.ihit && !killed; ins = bus.imemload;
    end
    return {ren, mPc, v, (v ? ins : 32'd0), mPc, mPc + 32'd4, mHalt};
  endfunction

  function automatic void modelStep();
    if (RST) begin
      mPc = 32'h0; mHold = 1'b0; mHalt = 1'b0;
    end else if (bus.redirect) begin
      mPc = bus.redirect_pc & 32'hFFFF_FFFC; mHold = 1'b0; mHalt = 1'b0;
    end else if (mHalt) begin
      mHalt = 1'b1;
    end else if (bus.flush) begin
      mHold = 1'b0;
    end else if (mHold) begin
      if (bus.advance) begin
        mHalt = (mBuf[31:26] == 6'h3F); mPc = mPc + 32'd4; mHold = 1'b0;
      end
    end else if (bus.ihit) begin
      if (bus.advance) begin
        mHalt = (bus.imemload[31:26] == 6'h3F); mPc = mPc + 32'd4;
      end else begin
        mHold = 1'b1; mBuf = bus.imemload;
      end
    end
  endfunction

  task automatic drive(input bit ih, input logic [31:0] ld, input bit adv, input bit fl,
                       input bit rd, input logic [31:0] rp);
    bus.ihit = ih; bus.imemload = ld; bus.advance = adv;
    bus.flush = fl; bus.redirect = rd; bus.redirect_pc = rp;
  endtask

  task automatic tick();
    @(posedge CLK);
    modelStep();
    #1;
  endtask

  task automatic test_reset();
    RST = 1'b1;
    drive(1'b1, rndInstr(), 1'b1, 1'b0, 1'b0, 32'h0);
    tick();
    @(negedge CLK);
    checks++;
    if ({bus.imemREN, bus.imemaddr, bus.if_valid, bus.halted} !== {1'b1, 32'h0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL reset_during: got ren/addr/valid/halted=%b/%h/%b/%b want 1/00000000/0/0",
               bus.imemREN, bus.imemaddr, bus.if_valid, bus.halted);
    end
    tick();
    RST = 1'b0;
    drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
    @(negedge CLK);
    checks++;
    if (actOut() !== {1'b1, 32'h0, 1'b0, 32'h0, 32'h0, 32'h4, 1'b0}) begin
      errors++;
      $display("FAIL reset_after: got %h want %h", actOut(), {1'b1, 32'h0, 1'b0, 32'h0, 32'h0, 32'h4, 1'b0});
    end
    tick();
  endtask

  task automatic test_sequential();
    logic [31:0] w;
    for (int i = 0; i < 3; i++) begin
      w = rndInstr();
      drive(1'b1, w, 1'b1, 1'b0, 1'b0, 32'h0);
      @(negedge CLK);
      checks++;
      if (actOut() !== {1'b1, 32'(i * 4), 1'b1, w, 32'(i * 4), 32'(i * 4 + 4), 1'b0}) begin
        errors++;
        $display("FAIL seq_fetch[%0d]: got %h want addr=%h instr=%h", i, actOut(), 32'(i * 4), w);
      end
      tick();
    end
  endtask

  task automatic test_hold();
    logic [31:0] p0;
    p0 = mPc;
    drive(1'b1, 32'h2008_0005, 1'b0, 1'b0, 1'b0, 32'h0);
    tick();
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, rndInstr(), 1'b0, 1'b0, 1'b0, 32'h0);
      @(negedge CLK);
      checks++;
      if ({bus.imemREN, bus.if_valid, bus.if_instr, bus.imemaddr, bus.if_pc} !== {1'b0, 1'b1, 32'h2008_0005, p0, p0}) begin
        errors++;
        $display("FAIL hold_stall[%0d]: got ren=%b v=%b instr=%h addr=%h pc=%h want 0 1 20080005 %h",
                 i, bus.imemREN, bus.if_valid, bus.if_instr, bus.imemaddr, bus.if_pc, p0);
      end
      tick();
    end
    drive(1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 32'h0);
    tick();
    drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
    @(negedge CLK);
    checks++;
    if ({bus.imemREN, bus.imemaddr} !== {1'b1, p0 + 32'd4}) begin
      errors++;
      $display("FAIL hold_release: got ren=%b addr=%h want 1 %h", bus.imemREN, bus.imemaddr, p0 + 32'd4);
    end
    tick();
  endtask

  task automatic test_redirect_hold();
    drive(1'b1, 32'h2008_0005, 1'b0, 1'b0, 1'b0, 32'h0);
    tick();
    drive(1'b0, 32'h0, 1'b1, 1'b0, 1'b1, 32'h0000_0100);
    @(negedge CLK);
    checks++;
    if (bus.if_valid !== 1'b0) begin
      errors++;
      $display("FAIL redir_kill: got if_valid=%b want 0", bus.if_valid);
    end
    tick();
    drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
    @(negedge CLK);
    checks++;
    if ({bus.imemREN, bus.imemaddr, bus.if_valid, bus.if_instr} !== {1'b1, 32'h100, 1'b0, 32'h0}) begin
      errors++;
      $display("FAIL redir_target: got ren=%b addr=%h v=%b instr=%h want 1 00000100 0 00000000",
               bus.imemREN, bus.imemaddr, bus.if_valid, bus.if_instr);
    end
    tick();
  endtask

  task automatic test_halt();
    logic [31:0] hp;
    hp = mPc;
    drive(1'b1, 32'hFC00_0000, 1'b1, 1'b0, 1'b0, 32'h0);
    tick();
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, rndInstr(), 1'b1, 1'b0, 1'b0, 32'h0);
      @(negedge CLK);
      checks++;
      if ({bus.halted, bus.imemREN, bus.if_valid, bus.imemaddr} !== {1'b1, 1'b0, 1'b0, hp + 32'd4}) begin
        errors++;
        $display("FAIL halt_hold[%0d]: got halted=%b ren=%b v=%b addr=%h want 1 0 0 %h",
                 i, bus.halted, bus.imemREN, bus.if_valid, bus.imemaddr, hp + 32'd4);
      end
      tick();
    end
    drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 32'h0000_0040);
    tick();
    drive(1'b1, 32'h2108_0001, 1'b1, 1'b0, 1'b0, 32'h0);
    @(negedge CLK);
    checks++;
    if (actOut() !== {1'b1, 32'h40, 1'b1, 32'h2108_0001, 32'h40, 32'h44, 1'b0}) begin
      errors++;
      $display("FAIL halt_resume: got %h want addr=00000040 valid instr=21080001 halted=0", actOut());
    end
    tick();
  endtask

  task automatic test_wrap_priority();
    drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 32'hFFFF_FFFC);
    tick();
    drive(1'b1, 32'h0000_0020, 1'b1, 1'b0, 1'b0, 32'h0);
    @(negedge CLK);
    checks++;
    if ({bus.imemaddr, bus.if_npc} !== {32'hFFFF_FFFC, 32'h0}) begin
      errors++;
      $display("FAIL wrap_npc: got addr=%h npc=%h want fffffffc 00000000", bus.imemaddr, bus.if_npc);
    end
    tick();
    drive(1'b1, 32'h0000_0020, 1'b1, 1'b1, 1'b1, 32'h0000_0203);
    @(negedge CLK);
    checks++;
    if ({bus.imemaddr, bus.if_valid} !== {32'h0, 1'b0}) begin
      errors++;
      $display("FAIL wrap_addr_prio_kill: got addr=%h v=%b want 00000000 0", bus.imemaddr, bus.if_valid);
    end
    tick();
    drive(1'b1, 32'h0000_0020, 1'b0, 1'b0, 1'b0, 32'h0);
    @(negedge CLK);
    checks++;
    if (bus.imemaddr !== 32'h0000_0200) begin
      errors++;
      $display("FAIL prio_fetch: got addr=%h want 00000200", bus.imemaddr);
    end
    tick();
    drive(1'b0, 32'h0, 1'b1, 1'b1, 1'b1, 32'h0000_0300);
    tick();
    drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
    @(negedge CLK);
    checks++;
    if ({bus.imemREN, bus.imemaddr, bus.if_valid} !== {1'b1, 32'h300, 1'b0}) begin
      errors++;
      $display("FAIL prio_hold: got ren=%b addr=%h v=%b want 1 00000300 0", bus.imemREN, bus.imemaddr, bus.if_valid);
    end
    tick();
  endtask

  task automatic test_reset_mid_hold();
    drive(1'b1, 32'h1234_5678, 1'b1, 1'b0, 1'b0, 32'h0);
    tick();
    drive(1'b1, 32'h2008_0005, 1'b0, 1'b0, 1'b0, 32'h0);
    tick();
    RST = 1'b1;
    drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
    tick();
    RST = 1'b0;
    @(negedge CLK);
    checks++;
    if ({bus.imemREN, bus.imemaddr, bus.if_valid, bus.if_pc, bus.if_instr} !== {1'b1, 32'h0, 1'b0, 32'h0, 32'h0}) begin
      errors++;
      $display("FAIL rst_mid_hold: got ren=%b addr=%h v=%b pc=%h instr=%h want 1 0 0 0 0",
               bus.imemREN, bus.imemaddr, bus.if_valid, bus.if_pc, bus.if_instr);
    end
    tick();
  endtask

  task automatic test_random();
    logic [31:0] w;
    for (int i = 0; i < 400; i++) begin
      RST = ($urandom_range(0, 99) == 0);
      w = ($urandom_range(0, 9) == 0) ? {6'h3F, 26'($urandom)} : rndInstr();
      drive($urandom_range(0, 9) < 7, w, $urandom_range(0, 1) == 1, $urandom_range(0, 9) == 0,
            $urandom_range(0, 11) == 0, $urandom);
      @(negedge CLK);
      if (!RST) begin
        checks++;
        if (actOut() !== expOut()) begin
          errors++;
          $display("FAIL random[%0d]: got %h want %h", i, actOut(), expOut());
        end
      end
      tick();
    end
    RST = 1'b0;
  endtask

  initial begin
    drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
    test_reset();
    test_sequential();
    test_hold();
    test_redirect_hold();
    test_halt();
    test_wrap_priority();
    test_reset_mid_hold();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
